// File: rtl/kp_color_threshold.sv
// Per-pixel RGB window test on three lockstep channel FIFOs, producing a match
// mask stream plus per-frame match count and bounding box.
module kp_color_threshold #(
    parameter int LINE_LENGTH = 640,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_enable,
    input  logic                                         i_flush,
    input  logic [DATA_WIDTH-1:0]                        i_r_data,
    input  logic [DATA_WIDTH-1:0]                        i_g_data,
    input  logic [DATA_WIDTH-1:0]                        i_b_data,
    input  logic                                         i_r_almostempty,
    input  logic                                         i_g_almostempty,
    input  logic                                         i_b_almostempty,
    output logic                                         o_rd,
    input  logic [3*DATA_WIDTH-1:0]                      i_thr_min,
    input  logic [3*DATA_WIDTH-1:0]                      i_thr_max,
    output logic                                         o_mask,
    output logic                                         o_mask_valid,
    output logic                                         o_frame_done,
    output logic [$clog2(LINE_LENGTH*LINE_COUNT+1)-1:0]  o_count,
    output logic                                         o_bbox_valid,
    output logic [$clog2(LINE_LENGTH)-1:0]               o_xmin,
    output logic [$clog2(LINE_LENGTH)-1:0]               o_xmax,
    output logic [$clog2(LINE_COUNT)-1:0]                o_ymin,
    output logic [$clog2(LINE_COUNT)-1:0]                o_ymax
);

    localparam int XW = $clog2(LINE_LENGTH);
    localparam int YW = $clog2(LINE_COUNT);
    localparam int CW = $clog2(LINE_LENGTH*LINE_COUNT+1);
    localparam int DW = DATA_WIDTH;

    logic          rd_d1_q, rd_d1_d;
    logic          mask_q, mask_d;
    logic          mask_valid_q, mask_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          bbox_valid_q, bbox_valid_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [XW-1:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [YW-1:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [XW-1:0] out_xmin_q, out_xmin_d, out_xmax_q, out_xmax_d;
    logic [YW-1:0] out_ymin_q, out_ymin_d, out_ymax_q, out_ymax_d;
    logic          match;
    logic          hit;
    logic          last_px;
    logic          has_hits;

    function automatic logic in_win(input logic [DW-1:0] d,
                                    input logic [DW-1:0] lo,
                                    input logic [DW-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign o_rd = i_enable && !i_r_almostempty && !i_g_almostempty &&
                  !i_b_almostempty && !i_rst && !i_flush;

    // An inverted window (min > max) can never satisfy both bounds, so it needs no special case.
    always_comb begin
        match = in_win(i_r_data, i_thr_min[3*DW-1:2*DW], i_thr_max[3*DW-1:2*DW]) &&
                in_win(i_g_data, i_thr_min[2*DW-1:DW],   i_thr_max[2*DW-1:DW])   &&
                in_win(i_b_data, i_thr_min[DW-1:0],      i_thr_max[DW-1:0]);
        rd_d1_d      = o_rd;
        mask_valid_d = rd_d1_q;
        mask_d       = rd_d1_q && match;
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        acc_cnt_d    = acc_cnt_q;
        acc_xmin_d   = acc_xmin_q;
        acc_xmax_d   = acc_xmax_q;
        acc_ymin_d   = acc_ymin_q;
        acc_ymax_d   = acc_ymax_q;
        out_cnt_d    = out_cnt_q;
        out_xmin_d   = out_xmin_q;
        out_xmax_d   = out_xmax_q;
        out_ymin_d   = out_ymin_q;
        out_ymax_d   = out_ymax_q;
        bbox_valid_d = bbox_valid_q;
        frame_done_d = 1'b0;
        has_hits     = 1'b0;

        hit     = mask_valid_q && mask_q;
        last_px = mask_valid_q && (x_q == XW'(LINE_LENGTH-1)) && (y_q == YW'(LINE_COUNT-1));

        if (hit) begin
            acc_cnt_d  = acc_cnt_q + CW'(1);
            acc_xmin_d = (x_q < acc_xmin_q) ? x_q : acc_xmin_q;
            acc_xmax_d = (x_q > acc_xmax_q) ? x_q : acc_xmax_q;
            acc_ymin_d = (y_q < acc_ymin_q) ? y_q : acc_ymin_q;
            acc_ymax_d = (y_q > acc_ymax_q) ? y_q : acc_ymax_q;
        end

        if (mask_valid_q) begin
            if (x_q == XW'(LINE_LENGTH-1)) begin
                x_d = '0;
                y_d = (y_q == YW'(LINE_COUNT-1)) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // Publish stats including the last pixel, then rearm the accumulators.
        if (last_px) begin
            has_hits     = (acc_cnt_d != '0);
            frame_done_d = 1'b1;
            out_cnt_d    = acc_cnt_d;
            bbox_valid_d = has_hits;
            out_xmin_d   = has_hits ? acc_xmin_d : '0;
            out_xmax_d   = has_hits ? acc_xmax_d : '0;
            out_ymin_d   = has_hits ? acc_ymin_d : '0;
            out_ymax_d   = has_hits ? acc_ymax_d : '0;
            acc_cnt_d    = '0;
            acc_xmin_d   = '1;
            acc_xmax_d   = '0;
            acc_ymin_d   = '1;
            acc_ymax_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_d1_q      <= 1'b0;
            mask_q       <= 1'b0;
            mask_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            bbox_valid_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            acc_cnt_q    <= '0;
            acc_xmin_q   <= '1;
            acc_xmax_q   <= '0;
            acc_ymin_q   <= '1;
            acc_ymax_q   <= '0;
            out_cnt_q    <= '0;
            out_xmin_q   <= '0;
            out_xmax_q   <= '0;
            out_ymin_q   <= '0;
            out_ymax_q   <= '0;
        end else begin
            rd_d1_q      <= rd_d1_d;
            mask_q       <= mask_d;
            mask_valid_q <= mask_valid_d;
            frame_done_q <= frame_done_d;
            bbox_valid_q <= bbox_valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_xmin_q   <= acc_xmin_d;
            acc_xmax_q   <= acc_xmax_d;
            acc_ymin_q   <= acc_ymin_d;
            acc_ymax_q   <= acc_ymax_d;
            out_cnt_q    <= out_cnt_d;
            out_xmin_q   <= out_xmin_d;
            out_xmax_q   <= out_xmax_d;
            out_ymin_q   <= out_ymin_d;
            out_ymax_q   <= out_ymax_d;
        end
    end

    assign o_mask       = mask_q;
    assign o_mask_valid = mask_valid_q;
    assign o_frame_done = frame_done_q;
    assign o_count      = out_cnt_q;
    assign o_bbox_valid = bbox_valid_q;
    assign o_xmin       = out_xmin_q;
    assign o_xmax       = out_xmax_q;
    assign o_ymin       = out_ymin_q;
    assign o_ymax       = out_ymax_q;

endmodule

// File: tb/tb_kp_color_threshold.sv
// Scoreboard bench for kp_color_threshold on an 8x4 frame: FIFO model feeds
// random pixels, a window/frame model predicts masks and frame statistics.
module tb_kp_color_threshold;

    localparam int LL = 8;
    localparam int LC = 4;
    localparam int DW = 8;
    localparam int XW = $clog2(LL);
    localparam int YW = $clog2(LC);
    localparam int CW = $clog2(LL*LC+1);
    localparam int DRAIN_LIMIT = 3000;

    typedef struct {
        int cnt;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
    } frame_t;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_enable = 1'b0;
    logic            i_flush;
    logic [DW-1:0]   i_r_data = '0;
    logic [DW-1:0]   i_g_data = '0;
    logic [DW-1:0]   i_b_data = '0;
    logic            i_r_almostempty = 1'b1;
    logic            i_g_almostempty = 1'b1;
    logic            i_b_almostempty = 1'b1;
    logic            o_rd;
    logic [3*DW-1:0] i_thr_min;
    logic [3*DW-1:0] i_thr_max;
    logic            o_mask;
    logic            o_mask_valid;
    logic            o_frame_done;
    logic [CW-1:0]   o_count;
    logic            o_bbox_valid;
    logic [XW-1:0]   o_xmin, o_xmax;
    logic [YW-1:0]   o_ymin, o_ymax;

    kp_color_threshold #(.LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
        .i_r_data(i_r_data), .i_g_data(i_g_data), .i_b_data(i_b_data),
        .i_r_almostempty(i_r_almostempty), .i_g_almostempty(i_g_almostempty),
        .i_b_almostempty(i_b_almostempty), .o_rd(o_rd),
        .i_thr_min(i_thr_min), .i_thr_max(i_thr_max),
        .o_mask(o_mask), .o_mask_valid(o_mask_valid), .o_frame_done(o_frame_done),
        .o_count(o_count), .o_bbox_valid(o_bbox_valid),
        .o_xmin(o_xmin), .o_xmax(o_xmax), .o_ymin(o_ymin), .o_ymax(o_ymax)
    );

    always #5 i_clk = ~i_clk;

    int     vectors = 0;
    int     miscompares = 0;
    int     src_r[$], src_g[$], src_b[$];
    bit     exp_mask[$];
    frame_t exp_frame[$];
    int     pix_idx = 0;
    int     m_cnt = 0, m_xmin = 0, m_xmax = 0, m_ymin = 0, m_ymax = 0;
    int     frames_seen = 0;
    bit     force_b = 1'b0;
    bit     en_base = 1'b0;
    bit     en_rand = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pix(input int r, input int g, input int b);
        src_r.push_back(r);
        src_g.push_back(g);
        src_b.push_back(b);
    endtask

    // Pixels are built for the window R[100,200] G[0,50] B[0,50]; the model decides the outcome.
    task automatic gen_pix(input bit want);
        int r, g, b;
        r = int'($urandom_range(0, 255));
        g = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        if (want) begin
            r = int'($urandom_range(100, 200));
            g = int'($urandom_range(0, 50));
            b = int'($urandom_range(0, 50));
        end else begin
            case ($urandom_range(0, 3))
                0: r = int'($urandom_range(0, 99));
                1: r = int'($urandom_range(201, 255));
                2: g = int'($urandom_range(51, 255));
                default: b = int'($urandom_range(51, 255));
            endcase
        end
        push_pix(r, g, b);
    endtask

    function automatic bit in_win(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // FIFO flags and enable are updated away from the sampling edge.
    always @(negedge i_clk) begin
        i_r_almostempty = (src_r.size() == 0);
        i_g_almostempty = (src_g.size() == 0);
        i_b_almostempty = (src_b.size() == 0) || force_b;
        i_enable = en_base && (!en_rand || ($urandom_range(0, 3) != 0));
    end

    // FIFO pop plus reference model: expected results are queued when a read is issued.
    always @(posedge i_clk) begin
        int r, g, b, x, y;
        bit m;
        frame_t f;
        if (i_rst || i_flush) begin
            exp_mask.delete();
            exp_frame.delete();
            pix_idx = 0;
            m_cnt = 0;
        end else if (o_rd) begin
            r = src_r.pop_front();
            g = src_g.pop_front();
            b = src_b.pop_front();
            i_r_data <= DW'(r);
            i_g_data <= DW'(g);
            i_b_data <= DW'(b);
            m = in_win(r, int'(i_thr_min[23:16]), int'(i_thr_max[23:16])) &&
                in_win(g, int'(i_thr_min[15:8]),  int'(i_thr_max[15:8]))  &&
                in_win(b, int'(i_thr_min[7:0]),   int'(i_thr_max[7:0]));
            exp_mask.push_back(m);
            x = pix_idx % LL;
            y = pix_idx / LL;
            if (m) begin
                if (m_cnt == 0) begin
                    m_xmin = x; m_xmax = x; m_ymin = y; m_ymax = y;
                end else begin
                    if (x < m_xmin) m_xmin = x;
                    if (x > m_xmax) m_xmax = x;
                    if (y < m_ymin) m_ymin = y;
                    if (y > m_ymax) m_ymax = y;
                end
                m_cnt++;
            end
            pix_idx++;
            if (pix_idx == LL*LC) begin
                f.cnt  = m_cnt;
                f.xmin = (m_cnt != 0) ? m_xmin : 0;
                f.xmax = (m_cnt != 0) ? m_xmax : 0;
                f.ymin = (m_cnt != 0) ? m_ymin : 0;
                f.ymax = (m_cnt != 0) ? m_ymax : 0;
                exp_frame.push_back(f);
                pix_idx = 0;
                m_cnt = 0;
            end
        end
    end

    always @(negedge i_clk) begin
        frame_t f;
        #1;
        if (o_mask_valid) begin
            if (exp_mask.size() == 0) check("mask_unexpected", int'(o_mask_valid), 0);
            else check("mask", int'(o_mask), int'(exp_mask.pop_front()));
        end
        if (o_frame_done) begin
            frames_seen++;
            if (exp_frame.size() == 0) begin
                check("frame_done_unexpected", int'(o_frame_done), 0);
            end else begin
                f = exp_frame.pop_front();
                check("frame_count", int'(o_count), f.cnt);
                check("frame_bbox_valid", int'(o_bbox_valid), int'(f.cnt != 0));
                check("frame_xmin", int'(o_xmin), f.xmin);
                check("frame_xmax", int'(o_xmax), f.xmax);
                check("frame_ymin", int'(o_ymin), f.ymin);
                check("frame_ymax", int'(o_ymax), f.ymax);
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((src_r.size() != 0 || exp_mask.size() != 0 || exp_frame.size() != 0) &&
               n < DRAIN_LIMIT) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_timeout", int'(n >= DRAIN_LIMIT), 0);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic set_thr(input int rlo, input int rhi, input int glo, input int ghi,
                           input int blo, input int bhi);
        i_thr_min = {DW'(rlo), DW'(glo), DW'(blo)};
        i_thr_max = {DW'(rhi), DW'(ghi), DW'(bhi)};
    endtask

    initial begin
        int k, rem;
        logic [31:0] want;
        i_rst = 1'b1;
        i_flush = 1'b0;
        set_thr(100, 200, 0, 50, 0, 50);

        // Boundary pixels, queued while still in reset.
        push_pix(150, 20, 20);
        push_pix(201, 20, 20);
        push_pix(100, 50, 50);
        push_pix(99, 0, 0);
        en_base = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        check("rd_in_reset", int'(o_rd), 0);
        check("mask_valid_in_reset", int'(o_mask_valid), 0);
        check("count_in_reset", int'(o_count), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rd_after_reset", int'(o_rd), 1);
        k = 0;
        do begin
            @(negedge i_clk);
            #1;
            k++;
        end while (!o_mask_valid && k < 10);
        check("first_mask_latency", k, 2);
        wait_drain();
        do_reset();

        // Inverted G window: nothing can match.
        set_thr(100, 200, 60, 10, 0, 50);
        want = $urandom;
        for (int i = 0; i < LL*LC; i++) gen_pix(want[i]);
        en_rand = 1'b1;
        wait_drain();
        en_rand = 1'b0;
        check("empty_count", int'(o_count), 0);
        check("empty_bbox_valid", int'(o_bbox_valid), 0);
        check("empty_xmin", int'(o_xmin), 0);
        check("empty_ymin", int'(o_ymin), 0);

        // Matches at (2,1), (5,1), (3,3) with random enable gaps.
        set_thr(100, 200, 0, 50, 0, 50);
        for (int i = 0; i < LL*LC; i++) gen_pix(i == 10 || i == 13 || i == 27);
        en_rand = 1'b1;
        wait_drain();
        en_rand = 1'b0;
        check("plan_count", int'(o_count), 3);
        check("plan_xmin", int'(o_xmin), 2);
        check("plan_xmax", int'(o_xmax), 5);
        check("plan_ymin", int'(o_ymin), 1);
        check("plan_ymax", int'(o_ymax), 3);
        check("plan_bbox_valid", int'(o_bbox_valid), 1);

        // Only B reports almost-empty: no reads may issue.
        force_b = 1'b1;
        @(negedge i_clk);
        for (int i = 0; i < 6; i++) gen_pix(1'($urandom_range(0, 1)));
        repeat (3) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            #1;
            check("rd_blocked_by_b", int'(o_rd), 0);
            check("valid_blocked_by_b", int'(o_mask_valid), 0);
        end
        force_b = 1'b0;

        // Flush at pixel 17 of the frame, then one full clean frame.
        for (int i = 0; i < LL*LC; i++) gen_pix(1'($urandom_range(0, 1)));
        k = 0;
        while (pix_idx != 17 && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        check("reach_pixel_17", int'(k >= 500), 0);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        #1;
        check("flush_count", int'(o_count), 0);
        check("flush_bbox_valid", int'(o_bbox_valid), 0);
        check("flush_xmax", int'(o_xmax), 0);
        check("flush_ymax", int'(o_ymax), 0);
        check("flush_mask_valid", int'(o_mask_valid), 0);
        check("flush_frame_done", int'(o_frame_done), 0);
        rem = src_r.size();
        for (int i = rem; i < LL*LC; i++) gen_pix(1'($urandom_range(0, 1)));
        en_rand = 1'b1;
        wait_drain();
        en_rand = 1'b0;
        check("frames_seen", frames_seen, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kp_color_threshold.md
Name: kp_color_threshold

Overview:
- Downstream consumer of the three per-channel Gaussian stages (R, G, B). Each channel has its own output FIFO.
- Pops one pixel from all three FIFOs in lockstep and tests it against an inclusive per-channel min/max window. Emits a 1-bit match mask stream.
- Tracks pixel coordinates and, per frame, accumulates match count and bounding box. Results feed the centroid/overlay logic.

Parameters:
- LINE_LENGTH, 640, pixels per line
- LINE_COUNT, 480, lines per frame
- DATA_WIDTH, 8, bits per colour channel

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_enable  in  1  stage enable; 0 = no FIFO reads issued
- i_flush  in  1  synchronous flush: same effect as reset, except i_thr_* untouched (inputs)
- i_r_data, i_g_data, i_b_data  in  DATA_WIDTH each  channel FIFO read data
- i_r_almostempty, i_g_almostempty, i_b_almostempty  in  1 each  channel FIFO almost-empty flags
- o_rd  out  1  common read strobe to all three FIFOs
- i_thr_min  in  3*DATA_WIDTH  {R,G,B} lower bounds, inclusive
- i_thr_max  in  3*DATA_WIDTH  {R,G,B} upper bounds, inclusive
- o_mask  out  1  match result for current pixel
- o_mask_valid  out  1  o_mask qualifier
- o_frame_done  out  1  one-cycle pulse; frame statistics valid
- o_count  out  $clog2(LINE_LENGTH*LINE_COUNT+1)  matched pixels in last frame
- o_bbox_valid  out  1  o_count != 0
- o_xmin, o_xmax  out  $clog2(LINE_LENGTH) each  bounding box columns
- o_ymin, o_ymax  out  $clog2(LINE_COUNT) each  bounding box rows

Behaviour:
- Reset / flush:
  - All outputs 0.
  - x/y counters 0.
  - Accumulators cleared: count 0, xmin/ymin all-ones sentinel, xmax/ymax 0.
  - Pipeline valid bits 0.
  - Reset has priority over every other event, including mid-frame. A partial frame is discarded and no o_frame_done is issued.
- Read issue (combinational): o_rd = i_enable && !i_r_almostempty && !i_g_almostempty && !i_b_almostempty && !i_rst && !i_flush.
  - The three FIFOs are always popped together, so channels never skew.
- FIFO contract: read data is valid the cycle after o_rd.
  - rd_d1 (registered o_rd) qualifies i_*_data.
- Pipeline stage 1 (cycle t+1 after rd at t): per-channel compare thr_min[c] <= data[c] <= thr_max[c], unsigned.
  - match = AND of all three channels.
  - If min > max on any channel, match is always 0.
- Stage 2 (t+2): o_mask/o_mask_valid registered. Fixed latency is 2 cycles from o_rd to o_mask_valid.
- Coordinate counters advance on every o_mask_valid.
  - x wraps LINE_LENGTH-1 -> 0 and increments y.
  - y wraps LINE_COUNT-1 -> 0.
- Accumulators update on o_mask_valid && o_mask: count+1; xmin/xmax/ymin/ymax updated with current x/y.
- Last pixel is (x = LINE_LENGTH-1, y = LINE_COUNT-1) with o_mask_valid. The following cycle:
  - o_frame_done pulses for 1 cycle.
  - o_count, o_bbox_valid and o_xmin..o_ymax are loaded with the final values, including the last pixel's contribution.
  - Accumulators are cleared for the next frame.
  - Output statistics hold until the next o_frame_done or reset.
- Empty frame: o_count = 0, o_bbox_valid = 0; bbox outputs 0 (not sentinel).
- i_enable deassert mid-stream: reads already issued complete through the pipeline. Counters and accumulators hold, and the frame resumes when re-enabled.
- Thresholds are sampled at stage 1. A change mid-frame affects subsequent pixels only.

Test Plan:
- Reset, all FIFOs non-empty, enable=1 → o_rd high from the first cycle after reset release; first o_mask_valid exactly 2 cycles after the first o_rd.
- Thresholds R[100,200] G[0,50] B[0,50]; pixels (150,20,20), (201,20,20), (100,50,50), (99,0,0) → masks 1, 0, 1, 0 (boundary inclusivity).
- LINE_LENGTH=8, LINE_COUNT=4; matches only at (2,1), (5,1), (3,3) → one o_frame_done after pixel 31 with count=3, xmin=2, xmax=5, ymin=1, ymax=3, bbox_valid=1.
- Same geometry, thr_min > thr_max on G → frame done with count=0, bbox_valid=0, bbox outputs 0.
- Only i_b_almostempty asserted → o_rd stays 0 and no valid output; deassert → reads resume with all three channels in lockstep.
- Assert i_flush at pixel 17 of an 8x4 frame → outputs and counters 0, no frame_done; next 32 pixels produce a correct frame_done.
